// File: rtl/sig_link_pkg.sv
// Shared types and constants for the sig_link point-to-point channel.
package sig_link_pkg;

    localparam int WIDTH_DEF = 1;
    localparam int DEPTH_DEF = 4;

    // Value every data-carrying output returns to on reset or when the FIFO is empty.
    localparam logic RESET_VAL = 1'b0;

    typedef logic [WIDTH_DEF-1:0] sig_t;

    // Width of a field that can hold the values 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sig_link_if.sv
// Channel bundle for sig_link.
//
// Handshake: a word moves from driver to channel on a rising edge where
// drv_valid && drv_ready, and from channel to receiver on a rising edge where
// rcv_valid && rcv_ready. Valid must not depend on ready. While valid is low,
// the data lines are don't-care.
interface sig_link_if
    import sig_link_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int CW = count_w(DEPTH);

    logic [WIDTH-1:0] drv_sig;
    logic             drv_valid;
    logic             drv_ready;
    logic [WIDTH-1:0] rcv_sig;
    logic             rcv_valid;
    logic             rcv_ready;
    logic [WIDTH-1:0] level;
    logic [CW-1:0]    count;

    // Producer/consumer side: offers words and drains the head.
    modport master (
        output drv_sig, drv_valid, rcv_ready,
        input  drv_ready, rcv_sig, rcv_valid, level, count
    );

    // Channel side.
    modport slave (
        input  drv_sig, drv_valid, rcv_ready,
        output drv_ready, rcv_sig, rcv_valid, level, count
    );

endinterface

// File: rtl/sig_link_fifo.sv
// In-order storage for sig_link: circular buffer with wrapping pointers and
// an exact occupancy counter. The caller guarantees no push when full and
// no pop when empty.
module sig_link_fifo
    import sig_link_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic [WIDTH-1:0]          i_wdata,
    input  logic                      i_pop,
    output logic [WIDTH-1:0]          o_rdata,
    output logic [count_w(DEPTH)-1:0] o_count,
    output logic                      o_full,
    output logic                      o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    // Storage write at the tail; contents are only read once written, so no reset.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer advance (natural wrap, DEPTH is a power of two) and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/sig_link.sv
// sig_link: registered driver-to-receiver signal channel. Keeps a level
// mirror of the last accepted word and a first-word-fall-through FIFO.
// Every output is a register or a decode of registers; no drv_* input
// reaches an rcv_* output combinationally.
module sig_link
    import sig_link_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    sig_link_if.slave  bus
);
    localparam int CW = count_w(DEPTH);

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_head;
    logic [CW-1:0]    w_count;
    logic [WIDTH-1:0] r_level;

    // Acceptance depends only on registered full/empty, so a pop on a full
    // FIFO does not free a slot for a push in the same cycle.
    assign w_push = bus.drv_valid & ~w_full;
    assign w_pop  = bus.rcv_ready & ~w_empty;

    sig_link_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (bus.drv_sig),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Level mirror follows every accepted word and holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= {WIDTH{RESET_VAL}};
        end else if (w_push) begin
            r_level <= bus.drv_sig;
        end
    end

    assign bus.drv_ready = ~w_full;
    assign bus.rcv_valid = ~w_empty;
    // Stale storage never leaks out while the FIFO is empty.
    assign bus.rcv_sig   = w_empty ? {WIDTH{RESET_VAL}} : w_head;
    assign bus.level     = r_level;
    assign bus.count     = w_count;

endmodule

// File: tb/tb_sig_link.sv
// Bench for sig_link with WIDTH=4, DEPTH=4. The reference model is a plain
// queue of accepted words plus the last accepted value.
module tb_sig_link;

  localparam int W = 4;
  localparam int D = 4;

  logic clk;
  logic rst;

  sig_link_if #(.WIDTH(W), .DEPTH(D)) bus ();

  sig_link #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] out_q[$];
  logic [W-1:0] m_level;
  int n_tests;
  int n_fail;
  bit chk_en;
  int sz;
  bit do_pop;
  bit do_push;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: on every falling edge compare outputs to the model, then apply
  // the transfers that the coming rising edge will perform.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      sz = exp_q.size();
      check("count", int'(bus.count), sz);
      check("rcv_valid", int'(bus.rcv_valid), (sz != 0) ? 1 : 0);
      check("drv_ready", int'(bus.drv_ready), (sz < D) ? 1 : 0);
      check("level", int'(bus.level), int'(m_level));
      check("rcv_sig", int'(bus.rcv_sig), (sz != 0) ? int'(exp_q[0]) : 0);
      do_pop  = (sz != 0) && bus.rcv_ready;
      do_push = bus.drv_valid && (sz < D);
      if (do_pop) begin
        out_q.push_back(exp_q[0]);
        void'(exp_q.pop_front());
      end
      if (do_push) begin
        exp_q.push_back(bus.drv_sig);
        m_level = bus.drv_sig;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_level = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"}, int'(bus.level), 0);
    check({tag, "_count"}, int'(bus.count), 0);
    check({tag, "_rcv_valid"}, int'(bus.rcv_valid), 0);
    check({tag, "_rcv_sig"}, int'(bus.rcv_sig), 0);
    check({tag, "_drv_ready"}, int'(bus.drv_ready), 1);
  endtask

  // Offer one word and hold it until accepted, randomising rcv_ready each cycle.
  task automatic push_value(input logic [W-1:0] v);
    int n;
    n = 0;
    bus.drv_sig   = v;
    bus.drv_valid = 1'b1;
    bus.rcv_ready = 1'($urandom_range(0, 1));
    while (!bus.drv_ready && n < 50) begin
      tick();
      bus.rcv_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (n >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: got drv_ready=0 for %0d cycles expected acceptance", n);
    end
    tick();
    bus.drv_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    bus.drv_valid = 1'b0;
    bus.rcv_ready = 1'b1;
    while (bus.rcv_valid && n < 20) begin
      tick();
      n++;
    end
    bus.rcv_ready = 1'b0;
    check({tag, "_drained_count"}, int'(bus.count), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] fill_vals [4];
    n_tests = 0;
    n_fail  = 0;
    chk_en  = 1'b0;
    model_reset();
    rst           = 1'b1;
    bus.drv_sig   = '0;
    bus.drv_valid = 1'b0;
    bus.rcv_ready = 1'b0;

    // Reset takes effect before any clock edge.
    #3;
    check_reset_outputs("por");
    tick();
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;

    // Single push with the receiver stalled.
    bus.drv_sig   = 4'd1;
    bus.drv_valid = 1'b1;
    tick();
    bus.drv_valid = 1'b0;
    bus.drv_sig   = 4'hf;
    check("single_level", int'(bus.level), 1);
    check("single_rcv_valid", int'(bus.rcv_valid), 1);
    check("single_rcv_sig", int'(bus.rcv_sig), 1);
    check("single_count", int'(bus.count), 1);
    drain("single");

    // Fill to full, then a fifth offer must be ignored.
    fill_vals[0] = 4'd1; fill_vals[1] = 4'd0; fill_vals[2] = 4'd1; fill_vals[3] = 4'd1;
    for (int i = 0; i < 4; i++) begin
      bus.drv_sig   = fill_vals[i];
      bus.drv_valid = 1'b1;
      tick();
    end
    bus.drv_valid = 1'b0;
    check("fill_count", int'(bus.count), 4);
    check("fill_drv_ready", int'(bus.drv_ready), 0);
    bus.drv_sig   = 4'd0;
    bus.drv_valid = 1'b1;
    tick();
    bus.drv_valid = 1'b0;
    check("full_level_held", int'(bus.level), 1);
    check("full_count_held", int'(bus.count), 4);

    // Full + pop + offered push: only the pop happens.
    bus.drv_sig   = 4'd6;
    bus.drv_valid = 1'b1;
    bus.rcv_ready = 1'b1;
    tick();
    bus.drv_valid = 1'b0;
    bus.rcv_ready = 1'b0;
    check("full_pop_count", int'(bus.count), 3);
    check("full_pop_level", int'(bus.level), 1);

    // Down to two entries, then push+pop for three cycles.
    bus.rcv_ready = 1'b1;
    tick();
    bus.rcv_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.drv_sig   = W'($urandom_range(0, 15));
      bus.drv_valid = 1'b1;
      bus.rcv_ready = 1'b1;
      tick();
      check("concurrent_count", int'(bus.count), 2);
    end
    drain("concurrent");

    // Stream 0..9 through the FIFO with a random receiver.
    out_q.delete();
    for (int v = 0; v < 10; v++) begin
      push_value(W'(v));
    end
    drain("wrap");
    check("wrap_out_len", out_q.size(), 10);
    for (int v = 0; v < 10 && v < out_q.size(); v++) begin
      check("wrap_order", int'(out_q[v]), v);
    end

    // Reset in the middle of a cycle with three entries queued.
    bus.drv_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.drv_sig = W'(7 + i);
      tick();
    end
    bus.drv_valid = 1'b0;
    check("pre_reset_count", int'(bus.count), 3);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid");
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    bus.drv_sig   = 4'd5;
    bus.drv_valid = 1'b1;
    tick();
    bus.drv_valid = 1'b0;
    check("post_reset_head", int'(bus.rcv_sig), 5);
    check("post_reset_count", int'(bus.count), 1);
    drain("post_reset");

    // Free-running random traffic.
    for (int i = 0; i < 300; i++) begin
      bus.drv_sig   = W'($urandom_range(0, 15));
      bus.drv_valid = 1'($urandom_range(0, 1));
      bus.rcv_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("random");

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
